// File: rtl/frame_gen_pkg.sv
// Shared types and default constants for the frame pattern generator:
// timing states, pattern codes, per-frame pattern configuration and bus widths.
package frame_gen_pkg;

    localparam int DEF_H_ACTIVE   = 640;
    localparam int DEF_V_ACTIVE   = 480;
    localparam int DEF_VBLANK_CYC = 19000;
    localparam int DEF_PRE_CYC    = 1000;
    localparam int DEF_BOX_X0     = 300;
    localparam int DEF_BOX_Y0     = 200;
    localparam int DEF_BOX_SIZE   = 32;

    localparam int DATA_W  = 12;
    localparam int COORD_W = 16;
    localparam int FCNT_W  = 32;
    localparam int CNT_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_VBLANK,
        ST_PRE,
        ST_ACTIVE
    } state_t;

    typedef enum logic [1:0] {
        PAT_RAMP  = 2'd0,
        PAT_ZERO  = 2'd1,
        PAT_CONST = 2'd2,
        PAT_BOX   = 2'd3
    } pattern_t;

    // Pattern selection captured once per frame.
    typedef struct packed {
        pattern_t            pattern;
        logic [DATA_W-1:0]   value;
    } pat_cfg_t;

endpackage

// File: rtl/frame_pattern_mux.sv
// Combinational pixel-value selector: ramp, zero, constant or constant-in-box,
// forced to zero whenever the pixel is not valid.
module frame_pattern_mux
    import frame_gen_pkg::*;
#(
    parameter int BOX_X0   = DEF_BOX_X0,
    parameter int BOX_Y0   = DEF_BOX_Y0,
    parameter int BOX_SIZE = DEF_BOX_SIZE
) (
    input  logic                i_valid,
    input  logic [COORD_W-1:0]  i_x,
    input  logic [COORD_W-1:0]  i_y,
    input  logic [DATA_W-1:0]   i_ramp,
    input  pat_cfg_t            i_cfg,
    output logic [DATA_W-1:0]   o_data
);

    logic [31:0] w_x;
    logic [31:0] w_y;
    logic        w_in_box;

    assign w_x = 32'(i_x);
    assign w_y = 32'(i_y);

    assign w_in_box = (w_x >= 32'(BOX_X0)) && (w_x < 32'(BOX_X0 + BOX_SIZE)) &&
                      (w_y >= 32'(BOX_Y0)) && (w_y < 32'(BOX_Y0 + BOX_SIZE));

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        o_data = '0;
        if (i_valid) begin
            case (i_cfg.pattern)
                PAT_RAMP:  o_data = i_ramp;
                PAT_ZERO:  o_data = '0;
                PAT_CONST: o_data = i_cfg.value;
                PAT_BOX:   if (w_in_box) o_data = i_cfg.value;
                default:   o_data = '0;
            endcase
        end
    end

endmodule

// File: rtl/frame_pattern_gen.sv
// Frame timing generator: IDLE/VBLANK/PRE/ACTIVE sequencing, pixel counters and
// fully registered video outputs; pixel values come from frame_pattern_mux.
module frame_pattern_gen
    import frame_gen_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int VBLANK_CYC = DEF_VBLANK_CYC,
    parameter int PRE_CYC    = DEF_PRE_CYC,
    parameter int BOX_X0     = DEF_BOX_X0,
    parameter int BOX_Y0     = DEF_BOX_Y0,
    parameter int BOX_SIZE   = DEF_BOX_SIZE
) (
    input  logic                iCLK,
    input  logic                iRST,
    input  logic                iEN,
    input  logic [1:0]          iPATTERN,
    input  logic [DATA_W-1:0]   iCONST,
    output logic                oFVAL,
    output logic                oDVAL,
    output logic [DATA_W-1:0]   oDATA,
    output logic [COORD_W-1:0]  oX_Cont,
    output logic [COORD_W-1:0]  oY_Cont,
    output logic [FCNT_W-1:0]   oFrame_Cont,
    output logic                oFrame_Done
);

    localparam logic [CNT_W-1:0]   VB_LAST  = CNT_W'(VBLANK_CYC - 1);
    localparam logic [CNT_W-1:0]   PRE_LAST = CNT_W'(PRE_CYC - 1);
    localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(V_ACTIVE - 1);

    state_t              r_state,  w_state_nxt;
    logic [CNT_W-1:0]    r_cnt,    w_cnt_nxt;
    logic [COORD_W-1:0]  r_x,      w_x_nxt;
    logic [COORD_W-1:0]  r_y,      w_y_nxt;
    logic [DATA_W-1:0]   r_ramp,   w_ramp_nxt;
    pat_cfg_t            r_cfg,    w_cfg_nxt;
    logic [DATA_W-1:0]   r_data,   w_data_nxt;
    logic                r_fval,   w_fval_nxt;
    logic                r_dval,   w_dval_nxt;
    logic                r_done,   w_frame_end;
    logic [FCNT_W-1:0]   r_frame_cnt;

    // The state register holds the state being shown on the outputs this cycle;
    // the cycle after the last pixel is already the first VBLANK (or IDLE) cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_x_nxt     = '0;
        w_y_nxt     = '0;
        w_ramp_nxt  = '0;
        w_cfg_nxt   = r_cfg;
        w_frame_end = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (iEN) begin
                    w_state_nxt = ST_VBLANK;
                    w_cnt_nxt   = '0;
                end
            end
            ST_VBLANK: begin
                if (r_cnt == VB_LAST) begin
                    w_state_nxt = ST_PRE;
                    w_cnt_nxt   = '0;
                    w_cfg_nxt   = '{pattern: pattern_t'(iPATTERN), value: iCONST};
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_PRE: begin
                if (r_cnt == PRE_LAST) begin
                    w_state_nxt = ST_ACTIVE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (r_x == X_LAST && r_y == Y_LAST) begin
                    w_frame_end = 1'b1;
                    w_state_nxt = iEN ? ST_VBLANK : ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_ramp_nxt = r_ramp + 1'b1;
                    if (r_x == X_LAST) begin
                        w_y_nxt = r_y + 1'b1;
                    end else begin
                        w_x_nxt = r_x + 1'b1;
                        w_y_nxt = r_y;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_fval_nxt = (w_state_nxt == ST_PRE) || (w_state_nxt == ST_ACTIVE);
    assign w_dval_nxt = (w_state_nxt == ST_ACTIVE);

    frame_pattern_mux #(
        .BOX_X0   (BOX_X0),
        .BOX_Y0   (BOX_Y0),
        .BOX_SIZE (BOX_SIZE)
    ) u_mux (
        .i_valid (w_dval_nxt),
        .i_x     (w_x_nxt),
        .i_y     (w_y_nxt),
        .i_ramp  (w_ramp_nxt),
        .i_cfg   (w_cfg_nxt),
        .o_data  (w_data_nxt)
    );

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_ramp      <= '0;
            r_cfg       <= '0;
            r_data      <= '0;
            r_fval      <= 1'b0;
            r_dval      <= 1'b0;
            r_done      <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            // NOTE: all state updates are non-blocking so every register sees pre-edge values.
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_x         <= w_x_nxt;
            r_y         <= w_y_nxt;
            r_ramp      <= w_ramp_nxt;
            r_cfg       <= w_cfg_nxt;
            r_data      <= w_data_nxt;
            r_fval      <= w_fval_nxt;
            r_dval      <= w_dval_nxt;
            r_done      <= w_frame_end;
            r_frame_cnt <= r_frame_cnt + FCNT_W'(w_frame_end);
        end
    end

    assign oFVAL       = r_fval;
    assign oDVAL       = r_dval;
    assign oDATA       = r_data;
    assign oX_Cont     = r_x;
    assign oY_Cont     = r_y;
    assign oFrame_Cont = r_frame_cnt;
    assign oFrame_Done = r_done;

endmodule

// File: tb/tb_frame_pattern_gen.sv
// Scoreboard bench for frame_pattern_gen on a small 8x4 frame: stimulus pushes
// expected pixels and frame counts, a negedge monitor pops and compares them.
module tb_frame_pattern_gen;

    localparam int H   = 8;
    localparam int V   = 4;
    localparam int VB  = 5;
    localparam int PRE = 3;
    localparam int BX  = 2;
    localparam int BY  = 1;
    localparam int BS  = 2;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [11:0] data;
    } pix_t;

    logic        iCLK;
    logic        iRST;
    logic        iEN;
    logic [1:0]  iPATTERN;
    logic [11:0] iCONST;
    logic        oFVAL;
    logic        oDVAL;
    logic [11:0] oDATA;
    logic [15:0] oX_Cont;
    logic [15:0] oY_Cont;
    logic [31:0] oFrame_Cont;
    logic        oFrame_Done;

    int          n_vectors     = 0;
    int          n_miscompares = 0;
    int          model_frames  = 0;
    pix_t        px_q[$];
    logic [31:0] done_q[$];

    frame_pattern_gen #(
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .VBLANK_CYC (VB),
        .PRE_CYC    (PRE),
        .BOX_X0     (BX),
        .BOX_Y0     (BY),
        .BOX_SIZE   (BS)
    ) dut (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .iEN         (iEN),
        .iPATTERN    (iPATTERN),
        .iCONST      (iCONST),
        .oFVAL       (oFVAL),
        .oDVAL       (oDVAL),
        .oDATA       (oDATA),
        .oX_Cont     (oX_Cont),
        .oY_Cont     (oY_Cont),
        .oFrame_Cont (oFrame_Cont),
        .oFrame_Done (oFrame_Done)
    );

    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_vectors++;
        n_miscompares++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [127:0] outs();
        return {49'd0, oFVAL, oDVAL, oDATA, oX_Cont, oY_Cont, oFrame_Cont, oFrame_Done};
    endfunction

    // Reference pixel value straight from the pattern definitions.
    function automatic logic [11:0] ref_pixel(input int pat, input int cst, input int x, input int y);
        case (pat)
            0:       return 12'((y * H + x) % 4096);
            1:       return 12'd0;
            2:       return 12'(cst);
            default: return (x >= BX && x < BX + BS && y >= BY && y < BY + BS) ? 12'(cst) : 12'd0;
        endcase
    endfunction

    task automatic push_frame(input int pat, input int cst);
        pix_t p;
        model_frames++;
        done_q.push_back(32'(model_frames));
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                p.x    = 16'(x);
                p.y    = 16'(y);
                p.data = ref_pixel(pat, cst, x, y);
                px_q.push_back(p);
            end
        end
    endtask

    task automatic set_cfg(input logic [1:0] pat, input logic [11:0] cst);
        iPATTERN = pat;
        iCONST   = cst;
        push_frame(int'(pat), int'(cst));
    endtask

    task automatic wait_pixels(input int n);
        int seen = 0;
        int cyc  = 0;
        while (seen < n && cyc < 2000) begin
            @(negedge iCLK);
            cyc++;
            if (oDVAL) seen++;
        end
        if (seen < n) fail("timeout_pixels");
    endtask

    task automatic wait_done();
        int cyc = 0;
        do begin
            @(negedge iCLK);
            cyc++;
        end while (!oFrame_Done && cyc < 2000);
        if (!oFrame_Done) fail("timeout_frame_done");
    endtask

    // From a release/enable on a falling edge: one edge into VBLANK, then VB cycles of VBLANK.
    task automatic measure_rise();
        int n = 0;
        do begin
            @(negedge iCLK);
            n++;
        end while (!oFVAL && n < 200);
        check("fval_rise_after_start", 128'(n), 128'(1 + VB));
    endtask

    // Disturb pattern inputs mid-frame (they must stay latched), then wait for frame end.
    task automatic finish_frame(input int scramble_at, input bit drop_en);
        wait_pixels(scramble_at);
        if (drop_en) begin
            iEN      = 1'b0;
            iPATTERN = 2'd2;
        end else begin
            iPATTERN = 2'($urandom);
        end
        iCONST = 12'($urandom);
        wait_done();
    endtask

    task automatic run_frame(input logic [1:0] pat, input logic [11:0] cst,
                             input int scramble_at, input bit drop_en);
        set_cfg(pat, cst);
        finish_frame(scramble_at, drop_en);
    endtask

    // Monitor: pops expected pixels and frame counts as the DUT presents them.
    initial begin
        int          low_run, pre_run, act_run;
        bit          gap_armed, prev_dval, prev_fval, prev_done;
        logic [15:0] prev_x, prev_y;
        pix_t        e;
        low_run = 0; pre_run = 0; act_run = 0;
        gap_armed = 0; prev_dval = 0; prev_fval = 0; prev_done = 0;
        prev_x = '0; prev_y = '0;
        forever begin
            @(negedge iCLK);
            if (iRST) begin
                low_run = 0; pre_run = 0; act_run = 0;
                gap_armed = 0; prev_dval = 0; prev_fval = 0; prev_done = 0;
                prev_x = '0; prev_y = '0;
            end else begin
                if (oDVAL) begin
                    if (px_q.size() == 0) begin
                        fail("pixel_unexpected");
                    end else begin
                        e = px_q.pop_front();
                        check("pixel_xyd", 128'({oX_Cont, oY_Cont, oDATA}), 128'({e.x, e.y, e.data}));
                    end
                    if (!oFVAL) fail("dval_without_fval");
                end else begin
                    check("blank_zero_xyd", 128'({oX_Cont, oY_Cont, oDATA}), 128'd0);
                end
                if (oFrame_Done) begin
                    if (done_q.size() == 0) fail("done_unexpected");
                    else check("frame_cont", 128'(oFrame_Cont), 128'(done_q.pop_front()));
                    check("done_after_last_pixel", 128'({prev_dval, prev_x, prev_y}),
                          128'({1'b1, 16'(H - 1), 16'(V - 1)}));
                    check("done_fval_low", 128'(oFVAL), 128'd0);
                    if (prev_done) fail("done_width");
                    gap_armed = iEN;
                    low_run   = 0;
                end
                if (!oFVAL) low_run++;
                if (oFVAL && !prev_fval) begin
                    if (gap_armed) check("vblank_len", 128'(low_run), 128'(VB));
                    gap_armed = 0;
                    pre_run   = 0;
                end
                if (oFVAL && !oDVAL) pre_run++;
                if (oDVAL && !prev_dval) begin
                    check("pre_len", 128'(pre_run), 128'(PRE));
                    act_run = 0;
                end
                if (oDVAL) act_run++;
                if (!oDVAL && prev_dval) check("active_len", 128'(act_run), 128'(H * V));
                prev_dval = oDVAL;
                prev_fval = oFVAL;
                prev_done = oFrame_Done;
                prev_x    = oX_Cont;
                prev_y    = oY_Cont;
            end
        end
    end

    initial begin
        iRST     = 1'b0;
        iEN      = 1'b0;
        iPATTERN = 2'd0;
        iCONST   = 12'd0;
        #1 iRST  = 1'b1;
        iEN      = 1'b1;
        #1 check("reset_outputs", outs(), 128'd0);
        repeat (3) @(negedge iCLK);
        check("reset_outputs_held", outs(), 128'd0);

        // First frame after release: ramp.
        set_cfg(2'd0, 12'h5A5);
        iRST = 1'b0;
        measure_rise();
        finish_frame(7, 1'b0);

        // Two more ramp frames, then the box frame.
        run_frame(2'd0, 12'($urandom), 15, 1'b0);
        run_frame(2'd0, 12'($urandom), 30, 1'b0);
        run_frame(2'd3, 12'd160, 12, 1'b0);

        for (int i = 0; i < 6; i++)
            run_frame(2'($urandom_range(0, 3)), 12'($urandom), $urandom_range(1, 31), 1'b0);

        // Enable dropped and pattern changed mid-frame: frame completes as ramp, then IDLE.
        run_frame(2'd0, 12'($urandom), 10, 1'b1);
        repeat (30) begin
            @(negedge iCLK);
            check("idle_fval_low", 128'(oFVAL), 128'd0);
        end

        // Reset mid-frame: outputs clear at once, no done pulse, frame count restarts.
        iEN = 1'b1;
        set_cfg(2'd0, 12'd0);
        wait_pixels(20);
        @(posedge iCLK);
        #2 iRST = 1'b1;
        #1 check("reset_midframe_outputs", outs(), 128'd0);
        px_q.delete();
        done_q.delete();
        model_frames = 0;
        repeat (3) @(negedge iCLK);
        set_cfg(2'd2, 12'($urandom));
        iRST = 1'b0;
        measure_rise();
        finish_frame(5, 1'b1);

        repeat (10) @(negedge iCLK);
        check("pixel_queue_drained", 128'(px_q.size()), 128'd0);
        check("done_queue_drained", 128'(done_q.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
